// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard receiver: synchronizes and filters the line, frames bytes, and
// decodes W/S/Up/Down make/break sequences into a held-key vector.
module ps2_paddle_keys #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [3:0]  key_held,
   output logic [31:0] scan_code,
   output logic        code_valid,
   output logic        frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic          filt_clk_q, filt_clk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          break_q, break_d;
   logic          ext_q, ext_d;
   logic [3:0]    key_q, key_d;
   logic [31:0]   scan_q, scan_d;
   logic          code_valid_q, code_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          filt_edge, filt_fall;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      filt_clk_d   = filt_clk_q;
      filt_cnt_d   = filt_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      break_d      = break_q;
      ext_d        = ext_q;
      key_d        = key_q;
      scan_d       = scan_q;
      code_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      // Filtered clock flips only after FILTER_LEN samples disagreeing with it.
      if (clk_sync_q == filt_clk_q) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
         filt_clk_d = clk_sync_q;
         filt_cnt_d = '0;
      end else begin
         filt_cnt_d = filt_cnt_q + 1'b1;
      end
      filt_edge = (filt_clk_d != filt_clk_q);
      filt_fall = filt_clk_q & ~filt_clk_d;

      if (filt_edge) begin
         tmo_cnt_d = '0;
      end else if (state_q != IDLE && tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
         if (tmo_cnt_d == TW'(TIMEOUT_CYCLES)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
         end
      end

      if (filt_fall) begin
         unique case (state_q)
            IDLE: begin
               if (!data_sync_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {data_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_d = data_sync_q;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (data_sync_q && (^shift_q ^ parity_q)) begin
                  code_valid_d = 1'b1;
                  scan_d       = {scan_q[23:0], shift_q};
                  if (shift_q == 8'hF0) begin
                     break_d = 1'b1;
                  end else if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else begin
                     case ({ext_q, shift_q})
                        9'h01D:  key_d[3] = ~break_q;
                        9'h01B:  key_d[2] = ~break_q;
                        9'h175:  key_d[1] = ~break_q;
                        9'h172:  key_d[0] = ~break_q;
                        default: ;
                     endcase
                     break_d = 1'b0;
                     ext_d   = 1'b0;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_meta_q   <= 1'b1;
         clk_sync_q   <= 1'b1;
         data_meta_q  <= 1'b1;
         data_sync_q  <= 1'b1;
         filt_clk_q   <= 1'b1;
         filt_cnt_q   <= '0;
         tmo_cnt_q    <= '0;
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         break_q      <= 1'b0;
         ext_q        <= 1'b0;
         key_q        <= '0;
         scan_q       <= '0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_meta_q   <= ps2_clk;
         clk_sync_q   <= clk_meta_q;
         data_meta_q  <= ps2_data;
         data_sync_q  <= data_meta_q;
         filt_clk_q   <= filt_clk_d;
         filt_cnt_q   <= filt_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         break_q      <= break_d;
         ext_q        <= ext_d;
         key_q        <= key_d;
         scan_q       <= scan_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign key_held   = key_q;
   assign scan_code  = scan_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Scoreboard bench for ps2_paddle_keys: stimulus pushes expected events,
// a monitor pops and compares on every code_valid / frame_err pulse.
module tb_ps2_paddle_keys;

   localparam int TMO  = 2000;
   localparam int HALF = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [3:0]  key_held;
   logic [31:0] scan_code;
   logic        code_valid;
   logic        frame_err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit          is_err;
      logic [31:0] sc;
      logic [3:0]  key;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_sc = '0;
   logic [3:0]  model_key = '0;

   ps2_paddle_keys #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_held   (key_held),
      .scan_code  (scan_code),
      .code_valid (code_valid),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_parity);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b) ^ bad_parity);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_clks(4 * HALF);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(b[i]);
      ps2_data = 1'b1;
   endtask

   // Good frame: model scan history shifts, key model set by caller beforehand.
   task automatic good(input logic [7:0] b, input logic [3:0] key_after);
      exp_t e;
      model_sc  = {model_sc[23:0], b};
      model_key = key_after;
      e.is_err = 1'b0; e.sc = model_sc; e.key = model_key;
      sb.push_back(e);
      send_frame(b, 1'b0);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1; e.sc = model_sc; e.key = model_key;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("scoreboard_drain", sb.size(), 0);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (code_valid || frame_err)) begin
            check("valid_err_exclusive", {31'b0, code_valid & frame_err}, 0);
            if (sb.size() == 0) begin
               check("unexpected_output", {30'b0, code_valid, frame_err}, 0);
            end else begin
               e = sb.pop_front();
               check("event_kind_err", {31'b0, frame_err}, {31'b0, e.is_err});
               check("scan_code", scan_code, e.sc);
               check("key_held", {28'b0, key_held}, {28'b0, e.key});
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      wait_clks(5);
      @(negedge clk);
      check("rst_key_held", {28'b0, key_held}, 0);
      check("rst_scan_code", scan_code, 0);
      check("rst_code_valid", {31'b0, code_valid}, 0);
      check("rst_frame_err", {31'b0, frame_err}, 0);
      reset = 1'b0;
      wait_clks(20);

      // Make / break of W
      good(8'h1D, 4'b1000);
      good(8'hF0, 4'b1000);
      good(8'h1D, 4'b0000);
      wait_drain(2000);
      check("scan_after_w", scan_code, 32'h001DF01D);

      // Extended Up arrow, bare keypad 75, extended break
      good(8'hE0, 4'b0000);
      good(8'h75, 4'b0010);
      good(8'h75, 4'b0010);
      good(8'hE0, 4'b0010);
      good(8'hF0, 4'b0010);
      good(8'h75, 4'b0000);
      wait_drain(2000);

      // Parity error, then good S
      push_err();
      send_frame(8'h1B, 1'b1);
      good(8'h1B, 4'b0100);
      wait_drain(2000);

      // Truncated frame -> timeout, then extended Down arrow
      push_err();
      send_partial(8'h55, 3);
      wait_clks(TMO + 500);
      wait_drain(100);
      good(8'hE0, 4'b0100);
      good(8'h72, 4'b0101);
      wait_drain(2000);

      // Short clock glitches with data low must never start a frame
      ps2_data = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0;
         wait_clks(3);
         ps2_clk = 1'b1;
         wait_clks(10);
      end
      ps2_data = 1'b1;
      wait_clks(TMO + 500);
      check("glitch_scan_code", scan_code, model_sc);
      check("glitch_key_held", {28'b0, key_held}, {28'b0, model_key});

      // Build key_held = 1001
      good(8'hF0, 4'b0101);
      good(8'h1B, 4'b0001);
      good(8'h1D, 4'b1001);
      wait_drain(2000);
      check("key_1001", {28'b0, key_held}, 32'h9);

      // Reset in the middle of a frame
      send_partial(8'h1D, 2);
      wait_clks(3);
      reset = 1'b1;
      wait_clks(3);
      @(negedge clk);
      check("midrst_key_held", {28'b0, key_held}, 0);
      check("midrst_scan_code", scan_code, 0);
      check("midrst_code_valid", {31'b0, code_valid}, 0);
      check("midrst_frame_err", {31'b0, frame_err}, 0);
      reset = 1'b0;
      model_sc  = '0;
      model_key = '0;
      wait_clks(20);

      // Flags were cleared by reset, so this is a plain make of S
      good(8'h1B, 4'b0100);
      wait_drain(2000);
      check("final_scan_code", scan_code, 32'h0000001B);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
